// File: rtl/bus_cmd_arbiter_if.sv
// Client request / event-handler command bundle for bus_cmd_arbiter.
// Per-client fields are flat-packed: client i at [i*W +: W].
interface bus_cmd_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int SLAVE_LEN = 2,
    parameter int ADDR_LEN  = 12,
    parameter int DATA_LEN  = 8,
    parameter int BURST_LEN = 12
);
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_write;
    logic [NUM_REQ*DATA_LEN-1:0]  req_data;
    logic [NUM_REQ*ADDR_LEN-1:0]  req_addr;
    logic [NUM_REQ*SLAVE_LEN-1:0] req_slave;
    logic [NUM_REQ*BURST_LEN-1:0] req_burst;
    logic [NUM_REQ-1:0]           req_ack;
    logic [NUM_REQ-1:0]           req_done;
    logic [NUM_REQ-1:0]           req_err;
    logic [NUM_REQ-1:0]           rd_valid;
    logic [DATA_LEN-1:0]          rd_data;

    logic                         eh_write;
    logic                         eh_read;
    logic [DATA_LEN-1:0]          eh_data;
    logic [ADDR_LEN-1:0]          eh_addr;
    logic [SLAVE_LEN-1:0]         eh_slave;
    logic [BURST_LEN-1:0]         eh_burst;
    logic                         eh_busy;
    logic                         eh_new_rx;
    logic [DATA_LEN-1:0]          eh_rx_data;

    // Arbiter side: serves the clients and masters the event handler.
    modport master (
        input  req_valid, req_write, req_data, req_addr, req_slave, req_burst,
        output req_ack, req_done, req_err, rd_valid, rd_data,
        output eh_write, eh_read, eh_data, eh_addr, eh_slave, eh_burst,
        input  eh_busy, eh_new_rx, eh_rx_data
    );

    // Environment side: clients plus the event handler.
    modport slave (
        output req_valid, req_write, req_data, req_addr, req_slave, req_burst,
        input  req_ack, req_done, req_err, rd_valid, rd_data,
        input  eh_write, eh_read, eh_data, eh_addr, eh_slave, eh_burst,
        output eh_busy, eh_new_rx, eh_rx_data
    );
endinterface

// File: rtl/bus_cmd_arbiter.sv
// Round-robin arbiter sharing one event-handler command port among NUM_REQ clients.
// Optional watchdog abort enabled by defining ARB_TIMEOUT_EN.
module bus_cmd_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int SLAVE_LEN      = 2,
    parameter int ADDR_LEN       = 12,
    parameter int DATA_LEN       = 8,
    parameter int BURST_LEN      = 12,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic               clk,
    input logic               reset,
    bus_cmd_arbiter_if.master bus
);
    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

    state_t           state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] grant;
    logic             wr_q;
    logic             cand_found;
    logic [IDX_W-1:0] cand_idx;
    logic [IDX_W-1:0] grant_next;

    // Scan from the farthest offset down so the nearest valid client wins.
    always_comb begin
        logic [IDX_W-1:0] idx;
        idx        = '0;
        cand_found = 1'b0;
        cand_idx   = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            idx = IDX_W'((int'(rr_ptr) + off) % NUM_REQ);
            if (bus.req_valid[idx]) begin
                cand_found = 1'b1;
                cand_idx   = idx;
            end
        end
    end

    assign grant_next = (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;

`ifdef ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] tmo_cnt;
`else
    assign bus.req_err = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            grant        <= '0;
            wr_q         <= 1'b0;
            bus.req_ack  <= '0;
            bus.req_done <= '0;
            bus.rd_valid <= '0;
            bus.rd_data  <= '0;
            bus.eh_write <= 1'b0;
            bus.eh_read  <= 1'b0;
            bus.eh_data  <= '0;
            bus.eh_addr  <= '0;
            bus.eh_slave <= SLAVE_LEN'(1);
            bus.eh_burst <= '0;
`ifdef ARB_TIMEOUT_EN
            bus.req_err  <= '0;
            tmo_cnt      <= '0;
`endif
        end else begin
            bus.req_ack  <= '0;
            bus.req_done <= '0;
            bus.rd_valid <= '0;
            bus.eh_write <= 1'b0;
            bus.eh_read  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            bus.req_err  <= '0;
`endif
            // Bytes landing on the busy-fall cycle still reach the client.
            if ((state == WAIT_BUSY || state == WAIT_DONE) && bus.eh_new_rx) begin
                bus.rd_valid[grant] <= 1'b1;
                bus.rd_data         <= bus.eh_rx_data;
            end

            case (state)
                IDLE: begin
                    if (cand_found) begin
                        grant                 <= cand_idx;
                        wr_q                  <= bus.req_write[cand_idx];
                        bus.eh_data           <= bus.req_data[cand_idx*DATA_LEN +: DATA_LEN];
                        bus.eh_addr           <= bus.req_addr[cand_idx*ADDR_LEN +: ADDR_LEN];
                        bus.eh_slave          <= bus.req_slave[cand_idx*SLAVE_LEN +: SLAVE_LEN];
                        bus.eh_burst          <= bus.req_burst[cand_idx*BURST_LEN +: BURST_LEN];
                        bus.req_ack[cand_idx] <= 1'b1;
                        state                 <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.eh_write <= wr_q;
                    bus.eh_read  <= ~wr_q;
                    state        <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (bus.eh_busy) state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (!bus.eh_busy) begin
                        bus.req_done[grant] <= 1'b1;
                        rr_ptr              <= grant_next;
                        state               <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

`ifdef ARB_TIMEOUT_EN
            // A normal completion on the same cycle takes precedence over the abort.
            if (state == WAIT_BUSY || state == WAIT_DONE) begin
                tmo_cnt <= tmo_cnt + 1'b1;
                if (tmo_cnt == TMO_LAST && !(state == WAIT_DONE && !bus.eh_busy)) begin
                    bus.req_done[grant] <= 1'b1;
                    bus.req_err[grant]  <= 1'b1;
                    rr_ptr              <= grant_next;
                    state               <= IDLE;
                end
            end else begin
                tmo_cnt <= '0;
            end
`endif
        end
    end
endmodule
